// File: rtl/firebird7_tdr_pkg.sv
// Shared definitions for the firebird7 IJTAG data TDR: default width, chain length, counter width, op decode.
// Define FIREBIRD7_TDR_PARITY_EN to add a parity bit at the top of the scan chain.
package firebird7_tdr_pkg;

  localparam int TDR_WIDTH_DEFAULT = 19;
  localparam int TDR_CNT_W         = 5;

  typedef enum logic [1:0] {
    TDR_OP_IDLE    = 2'd0,
    TDR_OP_CAPTURE = 2'd1,
    TDR_OP_SHIFT   = 2'd2,
    TDR_OP_UPDATE  = 2'd3
  } tdr_op_e;

  // Data bits, one select-control bit, plus the optional parity bit on top.
  function automatic int tdr_len(input int width);
`ifdef FIREBIRD7_TDR_PARITY_EN
    return width + 2;
`else
    return width + 1;
`endif
  endfunction

  // Capture outranks shift, which outranks update; nothing happens without select.
  function automatic tdr_op_e tdr_decode(input logic sel, input logic ce,
                                         input logic se, input logic ue);
    tdr_op_e op;
    op = TDR_OP_IDLE;
    if (sel) begin
      if (ce)      op = TDR_OP_CAPTURE;
      else if (se) op = TDR_OP_SHIFT;
      else if (ue) op = TDR_OP_UPDATE;
    end
    return op;
  endfunction

endpackage

// File: rtl/firebird7_tdr_shift_counter.sv
// Saturating shift counter; flags when exactly LEN shifts have been seen since the last capture/update.
module firebird7_tdr_shift_counter
  import firebird7_tdr_pkg::*;
#(
  parameter int LEN = 20
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_at_len
);

  localparam logic [TDR_CNT_W-1:0] LEN_CNT = TDR_CNT_W'(LEN);
  localparam logic [TDR_CNT_W-1:0] CNT_ONE = TDR_CNT_W'(1);

  logic [TDR_CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + CNT_ONE;
    end
  end

  assign o_at_len = (r_count == LEN_CNT);

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_tdr_w19.sv
// IJTAG data TDR driving a mux: scan chain of data + select bits with length-checked update.
// Define FIREBIRD7_TDR_PARITY_EN to add a captured parity bit that must match on update.
module firebird7_in_gate1_tessent_data_tdr_w19
  import firebird7_tdr_pkg::*;
#(
  parameter int               WIDTH       = TDR_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] capture_data_in,
  output logic [WIDTH-1:0] ijtag_data_out,
  output logic             ijtag_select_out,
  output logic             length_error
);

  localparam int LEN = tdr_len(WIDTH);

  tdr_op_e          w_op;
  logic             w_capture;
  logic             w_shift;
  logic             w_update;
  logic             w_len_ok;
  logic             w_parity_ok;
  logic             w_update_ok;
  logic [LEN-1:0]   w_capture_vec;

  logic [LEN-1:0]   r_shift;
  logic [WIDTH-1:0] r_data;
  logic             r_select;
  logic             r_error;

  assign w_op      = tdr_decode(ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue);
  assign w_capture = (w_op == TDR_OP_CAPTURE);
  assign w_shift   = (w_op == TDR_OP_SHIFT);
  assign w_update  = (w_op == TDR_OP_UPDATE);

`ifdef FIREBIRD7_TDR_PARITY_EN
  assign w_capture_vec = {^capture_data_in, r_select, capture_data_in};
  assign w_parity_ok   = (r_shift[LEN-1] == ^r_shift[WIDTH-1:0]);
`else
  assign w_capture_vec = {r_select, capture_data_in};
  assign w_parity_ok   = 1'b1;
`endif

  firebird7_tdr_shift_counter #(
    .LEN (LEN)
  ) u_shift_counter (
    .i_clk    (ijtag_tck),
    .i_rst    (ijtag_reset),
    .i_clear  (w_capture | w_update),
    .i_inc    (w_shift),
    .o_at_len (w_len_ok)
  );

  assign w_update_ok = w_len_ok & w_parity_ok;

  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      r_shift <= '0;
    end else if (w_capture) begin
      r_shift <= w_capture_vec;
    end else if (w_shift) begin
      r_shift <= {ijtag_si, r_shift[LEN-1:1]};
    end
  end

  // A short or corrupted load leaves the mux untouched and latches the error until reset.
  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      r_data   <= RESET_VALUE;
      r_select <= 1'b0;
      r_error  <= 1'b0;
    end else if (w_update) begin
      if (w_update_ok) begin
        r_data   <= r_shift[WIDTH-1:0];
        r_select <= r_shift[WIDTH];
      end else begin
        r_error  <= 1'b1;
      end
    end
  end

  assign ijtag_so         = r_shift[0];
  assign ijtag_data_out   = r_data;
  assign ijtag_select_out = r_select;
  assign length_error     = r_error;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_tdr_w19.sv
// Self-checking bench for the firebird7 data TDR against a queue-based chain model.
// Honours FIREBIRD7_TDR_PARITY_EN to match the RTL build.
`timescale 1ns/1ps
module tb_firebird7_in_gate1_tessent_data_tdr_w19;

  localparam int W = 19;
`ifdef FIREBIRD7_TDR_PARITY_EN
  localparam int L   = W + 2;
  localparam bit PAR = 1'b1;
`else
  localparam int L   = W + 1;
  localparam bit PAR = 1'b0;
`endif

  logic         ijtag_tck;
  logic         ijtag_reset;
  logic         ijtag_sel;
  logic         ijtag_ce;
  logic         ijtag_se;
  logic         ijtag_ue;
  logic         ijtag_si;
  logic         ijtag_so;
  logic [W-1:0] capture_data_in;
  logic [W-1:0] ijtag_data_out;
  logic         ijtag_select_out;
  logic         length_error;

  int checks   = 0;
  int failures = 0;

  bit           mChain[$];
  int           mCount;
  logic [W-1:0] mData;
  logic         mSel;
  logic         mErr;

  firebird7_in_gate1_tessent_data_tdr_w19 #(
    .WIDTH       (W),
    .RESET_VALUE ('0)
  ) dut (
    .ijtag_tck        (ijtag_tck),
    .ijtag_reset      (ijtag_reset),
    .ijtag_sel        (ijtag_sel),
    .ijtag_ce         (ijtag_ce),
    .ijtag_se         (ijtag_se),
    .ijtag_ue         (ijtag_ue),
    .ijtag_si         (ijtag_si),
    .ijtag_so         (ijtag_so),
    .capture_data_in  (capture_data_in),
    .ijtag_data_out   (ijtag_data_out),
    .ijtag_select_out (ijtag_select_out),
    .length_error     (length_error)
  );

  initial begin
    ijtag_tck = 1'b0;
    forever #5 ijtag_tck = ~ijtag_tck;
  end

  function automatic void modelReset();
    mChain.delete();
    for (int i = 0; i < L; i++) mChain.push_back(1'b0);
    mCount = 0;
    mData  = '0;
    mSel   = 1'b0;
    mErr   = 1'b0;
  endfunction

  // The model keeps the chain as a bit list with bit 0 at the front.
  function automatic void modelStep(input logic sel, input logic ce, input logic se,
                                    input logic ue, input logic si, input logic [W-1:0] cap);
    bit   parOk;
    logic x;
    if (!sel) return;
    if (ce) begin
      mChain.delete();
      for (int i = 0; i < W; i++) mChain.push_back(cap[i]);
      mChain.push_back(mSel);
      if (PAR) mChain.push_back(^cap);
      mCount = 0;
    end else if (se) begin
      void'(mChain.pop_front());
      mChain.push_back(si);
      mCount = (mCount < 31) ? mCount + 1 : 31;
    end else if (ue) begin
      x = 1'b0;
      for (int i = 0; i < W; i++) x = x ^ mChain[i];
      parOk = PAR ? (mChain[L-1] == x) : 1'b1;
      if (mCount == L && parOk) begin
        for (int i = 0; i < W; i++) mData[i] = mChain[i];
        mSel = mChain[W];
      end else begin
        mErr = 1'b1;
      end
      mCount = 0;
    end
  endfunction

  task automatic applyStimulus(input logic sel, input logic ce, input logic se,
                               input logic ue, input logic si, input logic [W-1:0] cap);
    @(negedge ijtag_tck);
    ijtag_sel = sel;
    ijtag_ce  = ce;
    ijtag_se  = se;
    ijtag_ue  = ue;
    ijtag_si  = si;
    capture_data_in = cap;
    @(posedge ijtag_tck);
    modelStep(sel, ce, se, ue, si, cap);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    checks++;
    assert (ijtag_so === mChain[0]) else begin
      failures++;
      $error("[TB] FAIL %s so: observed=%0b expected=%0b", tag, ijtag_so, mChain[0]);
    end
    checks++;
    assert (ijtag_data_out === mData) else begin
      failures++;
      $error("[TB] FAIL %s data_out: observed=%h expected=%h", tag, ijtag_data_out, mData);
    end
    checks++;
    assert (ijtag_select_out === mSel) else begin
      failures++;
      $error("[TB] FAIL %s select_out: observed=%0b expected=%0b", tag, ijtag_select_out, mSel);
    end
    checks++;
    assert (length_error === mErr) else begin
      failures++;
      $error("[TB] FAIL %s length_error: observed=%0b expected=%0b", tag, length_error, mErr);
    end
  endtask

  task automatic checkConst(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [W-1:0] randData();
    logic [31:0] r;
    r = $urandom();
    return r[W-1:0];
  endfunction

  // Chain image: data in the low bits, select above, parity (if built) on top.
  function automatic logic [31:0] chainVec(input logic [W-1:0] data, input logic sel, input bit goodPar);
    logic [31:0] v;
    v = '0;
    v[W-1:0] = data;
    v[W]     = sel;
    if (PAR) v[L-1] = goodPar ? ^data : ~^data;
    return v;
  endfunction

  task automatic doCapture(input logic [W-1:0] cap, input string tag);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, cap);
    checkOutput(tag);
  endtask

  task automatic doUpdate(input string tag);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, randData());
    checkOutput(tag);
  endtask

  task automatic shiftIn(input logic [31:0] vec, input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, vec[k], randData());
      checkOutput(tag);
    end
  endtask

  task automatic pulseReset(input string tag);
    @(negedge ijtag_tck);
    ijtag_sel = 1'b0;
    ijtag_ce  = 1'b0;
    ijtag_se  = 1'b0;
    ijtag_ue  = 1'b0;
    ijtag_reset = 1'b1;
    #2;
    modelReset();
    checkOutput(tag);
    #1;
    ijtag_reset = 1'b0;
  endtask

  logic [W-1:0] pattern5a;
  logic [31:0]  vec;

  initial begin
    ijtag_reset = 1'b1;
    ijtag_sel = 1'b0;
    ijtag_ce  = 1'b0;
    ijtag_se  = 1'b0;
    ijtag_ue  = 1'b0;
    ijtag_si  = 1'b0;
    capture_data_in = '0;
    modelReset();
    #12;
    checkOutput("reset");
    checkConst("reset_data_out", 32'(ijtag_data_out), 32'h0);
    checkConst("reset_select_out", 32'(ijtag_select_out), 32'h0);
    checkConst("reset_length_error", 32'(length_error), 32'h0);
    checkConst("reset_so", 32'(ijtag_so), 32'h0);
    @(negedge ijtag_tck);
    ijtag_reset = 1'b0;

    // Full-length load: capture 5A5A5, shift in {1,12345}, update.
    pattern5a = 19'h5A5A5;
    doCapture(pattern5a, "cap_5a5a5");
    checkConst("so_after_capture", 32'(ijtag_so), 32'(pattern5a[0]));
    vec = chainVec(19'h12345, 1'b1, 1'b1);
    for (int k = 0; k < L; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, vec[k], randData());
      checkOutput("shift_12345");
      if (k < 4) checkConst("so_stream_5a5a5", 32'(ijtag_so), 32'(pattern5a[k+1]));
    end
    doUpdate("upd_12345");
    checkConst("data_out_12345", 32'(ijtag_data_out), 32'h12345);
    checkConst("select_out_set", 32'(ijtag_select_out), 32'h1);
    checkConst("no_error_after_good_update", 32'(length_error), 32'h0);

    // One shift short: update suppressed and error latched.
    doCapture(randData(), "cap_short");
    shiftIn(chainVec(randData(), 1'b0, 1'b1), L - 1, "shift_short");
    doUpdate("upd_short");
    checkConst("short_data_held", 32'(ijtag_data_out), 32'h12345);
    checkConst("short_error_set", 32'(length_error), 32'h1);

    // A correct load afterwards still applies; the error stays sticky.
    doCapture(randData(), "cap_recover");
    shiftIn(chainVec(19'h2AAAA, 1'b0, 1'b1), L, "shift_recover");
    doUpdate("upd_recover");
    checkConst("recover_data", 32'(ijtag_data_out), 32'h2AAAA);
    checkConst("recover_select", 32'(ijtag_select_out), 32'h0);
    checkConst("recover_error_sticky", 32'(length_error), 32'h1);

    // ce and se together capture every cycle; the following update sees zero shifts.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, randData());
      checkOutput("ce_se_overlap");
    end
    doUpdate("upd_after_overlap");
    checkConst("overlap_data_held", 32'(ijtag_data_out), 32'h2AAAA);

    // Deselected: all enables ignored.
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, c[0], 1'b1, 1'b1, 1'b1, randData());
      checkOutput("deselected_hold");
    end

    // Reset in the middle of a shift sequence abandons it.
    doCapture(randData(), "cap_before_reset");
    shiftIn(chainVec(randData(), 1'b1, 1'b1), 10, "shift_before_reset");
    pulseReset("reset_mid_shift");
    doUpdate("upd_after_reset");
    checkConst("post_reset_data", 32'(ijtag_data_out), 32'h0);
    checkConst("post_reset_select", 32'(ijtag_select_out), 32'h0);

    // Random loads of random (sometimes wrong) length.
    for (int n = 0; n < 24; n++) begin
      int len;
      len = (n % 3 == 0) ? int'($urandom_range(L + 1, L - 2)) : L;
      doCapture(randData(), "rnd_cap");
      shiftIn(chainVec(randData(), 1'($urandom()), 1'b1), len, "rnd_shift");
      doUpdate("rnd_upd");
    end

    // Unconstrained random enables.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] r;
      r = $urandom();
      applyStimulus(r[0] | r[1], r[2] & r[3], r[4], r[5], r[6], randData());
      checkOutput("rnd_cycle");
    end

`ifdef FIREBIRD7_TDR_PARITY_EN
    pulseReset("reset_parity");
    doCapture(randData(), "cap_par_bad");
    shiftIn({11'd0, 1'b0, 1'b1, 19'h00001}, L, "shift_par_bad");
    doUpdate("upd_par_bad");
    checkConst("parity_bad_data_held", 32'(ijtag_data_out), 32'h0);
    checkConst("parity_bad_error", 32'(length_error), 32'h1);
    doCapture(randData(), "cap_par_good");
    shiftIn({11'd0, 1'b1, 1'b1, 19'h00001}, L, "shift_par_good");
    doUpdate("upd_par_good");
    checkConst("parity_good_data", 32'(ijtag_data_out), 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/firebird7_in_gate1_tessent_data_tdr_w19.md
FIREBIRD7_IN_GATE1_TESSENT_DATA_TDR_W19 -- requirements
Module: firebird7_in_gate1_tessent_data_tdr_w19

Interface
REQ-001 Parameter WIDTH, default 19, SHALL be the data field width; legal range 1..29.
REQ-002 Parameter RESET_VALUE, default 19'h0, SHALL be the reset value of the data update register.
REQ-003 ijtag_tck  input  1  SHALL be the only clock; all flops use its rising edge.
REQ-004 ijtag_reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 ijtag_sel  input  1  SHALL enable capture, shift and update for this register.
REQ-006 ijtag_ce / ijtag_se / ijtag_ue  input  1 each  SHALL be the capture, shift and update enables.
REQ-007 ijtag_si  input  1  SHALL be serial scan in; ijtag_so  output  1  SHALL be serial scan out.
REQ-008 capture_data_in  input  WIDTH  SHALL be the observed functional data, i.e. the mux data_out.
REQ-009 ijtag_data_out  output  WIDTH  SHALL drive the mux ijtag_data_in.
REQ-010 ijtag_select_out  output  1  SHALL drive the mux ijtag_select.
REQ-011 length_error  output  1  SHALL flag a suppressed update (sticky).

Function
REQ-012 Chain length LEN SHALL be WIDTH+1: bits [WIDTH-1:0] data, bit WIDTH select control.
REQ-013 Shift register SHALL shift toward bit 0: ijtag_si enters bit LEN-1; ijtag_so = bit 0 (combinational from flop).
REQ-014 Capture (sel&ce) SHALL load data bits from capture_data_in and control bit from current ijtag_select_out.
REQ-015 Shift (sel&se&!ce) SHALL move one bit per cycle.
REQ-016 Update (sel&ue&!ce&!se) SHALL load ijtag_data_out and ijtag_select_out from the shift register in the same edge; outputs change the cycle after.
REQ-017 Enables SHALL have priority ce > se > ue when several are asserted; with sel=0 all are ignored and all state holds.
REQ-018 A 5-bit shift counter SHALL clear on capture and on update, increment per shift, and saturate at 31.
REQ-019 Update SHALL occur only if counter == LEN; otherwise outputs hold and length_error sets.
REQ-020 length_error SHALL stay set until reset; later correct updates SHALL still be applied.
REQ-021 Update directly after reset or capture, with no shifts, SHALL be suppressed (counter 0 != LEN).

Reset
REQ-022 Reset SHALL asynchronously force: shift register 0, ijtag_data_out RESET_VALUE, ijtag_select_out 0, counter 0, length_error 0.
REQ-023 Reset asserted mid-shift SHALL abandon the sequence; next update without full capture/shift SHALL be suppressed.

Configuration
REQ-024 Macro FIREBIRD7_TDR_PARITY_EN SHALL, when defined, add bit LEN-1 (LEN=WIDTH+2) captured as XOR of capture_data_in and, on update, compared with XOR of shifted data bits; mismatch suppresses update and sets length_error.
REQ-025 Without FIREBIRD7_TDR_PARITY_EN, LEN SHALL be WIDTH+1 with no parity bit or check.

Structure
REQ-026 Shared package firebird7_tdr_pkg SHALL hold WIDTH default, LEN computation function, counter width and the capture/shift/update priority enum.
REQ-027 One sub-module firebird7_tdr_shift_counter (clear/increment/saturate, compare to LEN) SHALL be used; remaining logic inline.

Verification
REQ-028 Reset -> ijtag_data_out=0, ijtag_select_out=0, length_error=0, ijtag_so=0.
REQ-029 capture_data_in=19'h5A5A5, capture, 20 shifts of {1'b1,19'h12345} LSB-first, update -> ijtag_so emits 1,0,1,0,0,... (h5A5A5 LSB-first); ijtag_data_out=19'h12345, ijtag_select_out=1.
REQ-030 Capture, 19 shifts, update -> outputs unchanged, length_error=1; then full 20-shift sequence -> update applied, length_error stays 1.
REQ-031 ce and se both high with sel for 3 cycles -> capture each cycle, no shift, counter 0.
REQ-032 Reset pulse after 10 shifts, then ue -> update suppressed, outputs at reset values.
REQ-033 With FIREBIRD7_TDR_PARITY_EN: 21-shift load of 19'h00001 with parity bit 0 -> update suppressed, length_error=1; with parity bit 1 -> applied.
